cisr_channel_feeder: RTL and testbench

//  Parametrised CISR stream feeder for the SpMV datapath. Fetches packed slot words
//  ({matrix_val,col_id} per channel) and packed row_len words from two on-chip read

---
 rtl/cisr_channel_feeder.sv | 154 +++++++++++++++
 tb/tb_cisr_channel_feeder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cisr_channel_feeder.sv
// CISR stream feeder: fetches packed slot and row_len words from two read ports
// and demultiplexes them into per-channel FWFT FIFOs, dropping padding entries.
module cisr_channel_feeder #(
    parameter int CHANNELS   = 4,
    parameter int VAL_W      = 32,
    parameter int COL_W      = 16,
    parameter int LEN_W      = 16,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ADDR_W-1:0]                 slot_base,
    input  logic [ADDR_W-1:0]                 slot_count,
    input  logic [ADDR_W-1:0]                 len_base,
    input  logic [ADDR_W-1:0]                 len_count,
    output logic [ADDR_W-1:0]                 slot_addr,
    output logic                              slot_rd_en,
    input  logic [CHANNELS*(VAL_W+COL_W)-1:0] slot_data,
    output logic [ADDR_W-1:0]                 len_addr,
    output logic                              len_rd_en,
    input  logic [CHANNELS*LEN_W-1:0]         len_data,
    output logic [CHANNELS*VAL_W-1:0]         matrix_val,
    output logic [CHANNELS*COL_W-1:0]         col_id,
    output logic [CHANNELS-1:0]               nz_empty,
    input  logic [CHANNELS-1:0]               nz_rd_en,
    output logic [CHANNELS*LEN_W-1:0]         row_len,
    output logic [CHANNELS-1:0]               row_len_empty,
    input  logic [CHANNELS-1:0]               row_len_rd_en,
    output logic                              busy,
    output logic                              done
);

    localparam int SLOT_W = VAL_W + COL_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   slot_left, len_left;
    logic                slot_inflight, len_inflight;
    logic [CHANNELS-1:0] nz_room, len_room;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                if (slot_left == '0 && len_left == '0) state_next = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (!slot_inflight && !len_inflight) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A read is only issued when every FIFO can absorb it plus the word already in flight.
    assign slot_rd_en = !rst && (state == FETCH) && (slot_left != '0) && (&nz_room);
    assign len_rd_en  = !rst && (state == FETCH) && (len_left != '0) && (&len_room);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_addr     <= '0;
            len_addr      <= '0;
            slot_left     <= '0;
            len_left      <= '0;
            slot_inflight <= 1'b0;
            len_inflight  <= 1'b0;
        end else begin
            slot_inflight <= slot_rd_en;
            len_inflight  <= len_rd_en;
            if (state == IDLE && start) begin
                slot_addr <= slot_base;
                slot_left <= slot_count;
                len_addr  <= len_base;
                len_left  <= len_count;
            end else begin
                if (slot_rd_en) begin
                    slot_addr <= slot_addr + ADDR_W'(1);
                    slot_left <= slot_left - ADDR_W'(1);
                end
                if (len_rd_en) begin
                    len_addr <= len_addr + ADDR_W'(1);
                    len_left <= len_left - ADDR_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SLOT_W-1:0] nz_mem [FIFO_DEPTH];
        logic [LEN_W-1:0]  len_mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  nz_wp, nz_rp, len_wp, len_rp;
        logic [CNT_W-1:0]  nz_cnt, len_cnt;
        logic              nz_push, nz_pop, len_push, len_pop;

        assign nz_push  = slot_inflight && (slot_data[g*SLOT_W +: COL_W] != {COL_W{1'b1}});
        assign nz_pop   = nz_rd_en[g] && (nz_cnt != '0);
        assign len_push = len_inflight;
        assign len_pop  = row_len_rd_en[g] && (len_cnt != '0);

        always_ff @(posedge clk) begin
            if (nz_push)  nz_mem[nz_wp]   <= slot_data[g*SLOT_W +: SLOT_W];
            if (len_push) len_mem[len_wp] <= len_data[g*LEN_W +: LEN_W];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                nz_wp   <= '0;
                nz_rp   <= '0;
                nz_cnt  <= '0;
                len_wp  <= '0;
                len_rp  <= '0;
                len_cnt <= '0;
            end else begin
                if (nz_push) nz_wp <= nz_wp + PTR_W'(1);
                if (nz_pop)  nz_rp <= nz_rp + PTR_W'(1);
                if (nz_push && !nz_pop)      nz_cnt <= nz_cnt + CNT_W'(1);
                else if (!nz_push && nz_pop) nz_cnt <= nz_cnt - CNT_W'(1);
                if (len_push) len_wp <= len_wp + PTR_W'(1);
                if (len_pop)  len_rp <= len_rp + PTR_W'(1);
                if (len_push && !len_pop)      len_cnt <= len_cnt + CNT_W'(1);
                else if (!len_push && len_pop) len_cnt <= len_cnt - CNT_W'(1);
            end
        end

        assign matrix_val[g*VAL_W +: VAL_W] = nz_mem[nz_rp][COL_W +: VAL_W];
        assign col_id[g*COL_W +: COL_W]     = nz_mem[nz_rp][0 +: COL_W];
        assign nz_empty[g]                  = (nz_cnt == '0);
        assign row_len[g*LEN_W +: LEN_W]    = len_mem[len_rp];
        assign row_len_empty[g]             = (len_cnt == '0);

        assign nz_room[g]  = ({1'b0, nz_cnt} + {{CNT_W{1'b0}}, slot_inflight}) < (CNT_W+1)'(FIFO_DEPTH);
        assign len_room[g] = ({1'b0, len_cnt} + {{CNT_W{1'b0}}, len_inflight}) < (CNT_W+1)'(FIFO_DEPTH);
    end

endmodule

// File: tb/tb_cisr_channel_feeder.sv
// Bench for cisr_channel_feeder: a queue-based model of the per-channel streams
// checked every cycle, plus directed runs with hand-computed expectations.
module tb_cisr_channel_feeder;

    localparam int CH     = 4;
    localparam int VAL_W  = 32;
    localparam int COL_W  = 16;
    localparam int LEN_W  = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;
    localparam int SLOT_W = VAL_W + COL_W;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [ADDR_W-1:0]       slot_base = '0, slot_count = '0, len_base = '0, len_count = '0;
    logic [ADDR_W-1:0]       slot_addr, len_addr;
    logic                    slot_rd_en, len_rd_en;
    logic [CH*SLOT_W-1:0]    slot_data;
    logic [CH*LEN_W-1:0]     len_data;
    logic [CH*VAL_W-1:0]     matrix_val;
    logic [CH*COL_W-1:0]     col_id;
    logic [CH-1:0]           nz_empty, row_len_empty;
    logic [CH-1:0]           nz_rd_en = '0, row_len_rd_en = '0;
    logic [CH*LEN_W-1:0]     row_len;
    logic                    busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cisr_channel_feeder #(
        .CHANNELS(CH), .VAL_W(VAL_W), .COL_W(COL_W), .LEN_W(LEN_W),
        .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .slot_base(slot_base), .slot_count(slot_count),
        .len_base(len_base), .len_count(len_count),
        .slot_addr(slot_addr), .slot_rd_en(slot_rd_en), .slot_data(slot_data),
        .len_addr(len_addr), .len_rd_en(len_rd_en), .len_data(len_data),
        .matrix_val(matrix_val), .col_id(col_id), .nz_empty(nz_empty), .nz_rd_en(nz_rd_en),
        .row_len(row_len), .row_len_empty(row_len_empty), .row_len_rd_en(row_len_rd_en),
        .busy(busy), .done(done)
    );

    // Memories with one cycle of read latency; unstrobed cycles return a non-padding junk word.
    logic [CH*SLOT_W-1:0] slot_mem [256];
    logic [CH*LEN_W-1:0]  len_mem  [256];

    always @(posedge clk) begin
        slot_data <= slot_rd_en ? slot_mem[slot_addr[7:0]] : {CH{48'h0BAD_0BAD_0001}};
        len_data  <= len_rd_en ? len_mem[len_addr[7:0]] : {CH{16'hBEEF}};
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel queues of what each FIFO must hold, fed from memory words
    // the feeder is expected to request in address order, one per cycle while room allows.
    logic [SLOT_W-1:0] nz_q  [CH][$];
    logic [LEN_W-1:0]  len_q [CH][$];
    int                phase = 0;
    int                slot_rem = 0, len_rem = 0;
    logic [ADDR_W-1:0] m_slot_addr = '0, m_len_addr = '0;
    logic [ADDR_W-1:0] slot_pend_addr = '0, len_pend_addr = '0;
    bit                slot_pend = 1'b0, len_pend = 1'b0;

    always @(negedge clk) begin
        bit                   exp_slot, exp_len, nothing_left;
        logic [CH*SLOT_W-1:0] w;
        logic [CH*LEN_W-1:0]  lw;
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                nz_q[k].delete();
                len_q[k].delete();
            end
            phase = 0; slot_rem = 0; len_rem = 0;
            slot_pend = 1'b0; len_pend = 1'b0;
        end else begin
            nothing_left = (slot_rem == 0) && (len_rem == 0);
            exp_slot = (phase == 1) && (slot_rem > 0);
            exp_len  = (phase == 1) && (len_rem > 0);
            for (int k = 0; k < CH; k++) begin
                if (nz_q[k].size() + int'(slot_pend) > DEPTH - 1) exp_slot = 1'b0;
                if (len_q[k].size() + int'(len_pend) > DEPTH - 1) exp_len = 1'b0;
            end
            checkOutput("busy", busy, phase != 0);
            checkOutput("done", done, phase == 2);
            checkOutput("slot_rd_en", slot_rd_en, exp_slot);
            if (exp_slot) checkOutput("slot_addr", slot_addr, m_slot_addr);
            checkOutput("len_rd_en", len_rd_en, exp_len);
            if (exp_len) checkOutput("len_addr", len_addr, m_len_addr);
            for (int k = 0; k < CH; k++) begin
                checkOutput("nz_empty", nz_empty[k], nz_q[k].size() == 0);
                if (nz_q[k].size() > 0)
                    checkOutput("nz_head", {matrix_val[k*VAL_W +: VAL_W], col_id[k*COL_W +: COL_W]}, nz_q[k][0]);
                checkOutput("row_len_empty", row_len_empty[k], len_q[k].size() == 0);
                if (len_q[k].size() > 0)
                    checkOutput("row_len_head", row_len[k*LEN_W +: LEN_W], len_q[k][0]);
            end
            for (int k = 0; k < CH; k++) begin
                if (nz_rd_en[k] && nz_q[k].size() > 0) void'(nz_q[k].pop_front());
                if (row_len_rd_en[k] && len_q[k].size() > 0) void'(len_q[k].pop_front());
            end
            if (slot_pend) begin
                w = slot_mem[slot_pend_addr[7:0]];
                for (int k = 0; k < CH; k++)
                    if (w[k*SLOT_W +: COL_W] != {COL_W{1'b1}}) nz_q[k].push_back(w[k*SLOT_W +: SLOT_W]);
            end
            if (len_pend) begin
                lw = len_mem[len_pend_addr[7:0]];
                for (int k = 0; k < CH; k++) len_q[k].push_back(lw[k*LEN_W +: LEN_W]);
            end
            slot_pend = exp_slot; slot_pend_addr = m_slot_addr;
            len_pend  = exp_len;  len_pend_addr  = m_len_addr;
            if (exp_slot) begin m_slot_addr = m_slot_addr + 16'd1; slot_rem--; end
            if (exp_len)  begin m_len_addr  = m_len_addr + 16'd1;  len_rem--;  end
            if (phase == 2) phase = 0;
            else if (phase == 1 && nothing_left) phase = 2;
            else if (phase == 0 && start) begin
                phase = 1;
                m_slot_addr = slot_base; slot_rem = int'(slot_count);
                m_len_addr  = len_base;  len_rem  = int'(len_count);
            end
        end
    end

    // Raw observations of the DUT for the directed count checks.
    int slot_strobes = 0;
    int done_cnt = 0;
    int pop_nz [CH];
    int pop_len [CH];

    initial begin
        for (int k = 0; k < CH; k++) begin pop_nz[k] = 0; pop_len[k] = 0; end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (slot_rd_en) slot_strobes++;
            if (done) done_cnt++;
            for (int k = 0; k < CH; k++) begin
                if (nz_rd_en[k] && !nz_empty[k]) pop_nz[k]++;
                if (row_len_rd_en[k] && !row_len_empty[k]) pop_len[k]++;
            end
        end
    end

    function automatic logic [CH*SLOT_W-1:0] make_slot(input int tag, input int i, input logic [CH-1:0] pad);
        logic [CH*SLOT_W-1:0] w;
        w = '0;
        for (int k = 0; k < CH; k++) begin
            w[k*SLOT_W+COL_W +: VAL_W] = 32'(tag*65536 + i*16 + k);
            w[k*SLOT_W +: COL_W]       = pad[k] ? 16'hFFFF : 16'(tag*256 + i*4 + k);
        end
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] sb, input logic [ADDR_W-1:0] sc,
                                 input logic [ADDR_W-1:0] lb, input logic [ADDR_W-1:0] lc);
        slot_base = sb; slot_count = sc; len_base = lb; len_count = lc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200 && busy; i++) tick(1);
        checkOutput("idle_timeout", busy, 1'b0);
    endtask

    task automatic drain();
        nz_rd_en = '1; row_len_rd_en = '1;
        for (int i = 0; i < 100 && !((&nz_empty) && (&row_len_empty)); i++) tick(1);
        nz_rd_en = '0; row_len_rd_en = '0;
        checkOutput("drain_timeout", {nz_empty, row_len_empty}, 8'hFF);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired: got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d0, s0;
        int p0 [CH];
        int l0 [CH];

        // Reset for two cycles.
        tick(2);
        rst = 1'b0;
        checkOutput("t1_nz_empty", nz_empty, 4'hF);
        checkOutput("t1_row_len_empty", row_len_empty, 4'hF);
        checkOutput("t1_busy", busy, 1'b0);
        checkOutput("t1_strobes", {slot_rd_en, len_rd_en, done}, 3'b000);
        tick(1);

        // Three-word run: consecutive addresses, head appears two cycles after the first strobe.
        for (int i = 0; i < 3; i++) slot_mem[8'h10 + i] = make_slot(2, i, 4'b0000);
        d0 = done_cnt;
        p0 = pop_nz;
        applyStimulus(16'h10, 16'd3, 16'h0, 16'd0);
        checkOutput("t2_addr0", {slot_rd_en, slot_addr}, {1'b1, 16'h0010});
        tick(1);
        checkOutput("t2_addr1", {slot_rd_en, slot_addr}, {1'b1, 16'h0011});
        checkOutput("t2_ch0_empty_early", nz_empty[0], 1'b1);
        tick(1);
        checkOutput("t2_addr2", {slot_rd_en, slot_addr}, {1'b1, 16'h0012});
        checkOutput("t2_ch0_empty", nz_empty[0], 1'b0);
        checkOutput("t2_ch0_val", matrix_val[31:0], 32'h0002_0000);
        checkOutput("t2_ch0_col", col_id[15:0], 16'h0200);
        waitIdle();
        tick(1);
        checkOutput("t2_done_count", done_cnt - d0, 1);
        drain();
        checkOutput("t2_ch0_pops", pop_nz[0] - p0[0], 3);
        checkOutput("t2_ch3_pops", pop_nz[3] - p0[3], 3);

        // Back-pressure: stalled consumers cap each FIFO at DEPTH words.
        for (int i = 0; i < 20; i++) slot_mem[8'h20 + i] = make_slot(3, i, 4'b0000);
        s0 = slot_strobes;
        p0 = pop_nz;
        applyStimulus(16'h20, 16'd20, 16'h0, 16'd0);
        tick(25);
        checkOutput("t3_stall_strobes", slot_strobes - s0, 8);
        checkOutput("t3_stall_busy", busy, 1'b1);
        nz_rd_en = 4'b0100;
        tick(3);
        nz_rd_en = '0;
        tick(5);
        checkOutput("t3_partial_pop_strobes", slot_strobes - s0, 8);
        checkOutput("t3_other_full", nz_empty, 4'b0000);
        nz_rd_en = '1;
        waitIdle();
        drain();
        for (int k = 0; k < CH; k++) checkOutput("t3_pops", pop_nz[k] - p0[k], 20);

        // Padding on ch1 in words 0 and 2.
        for (int i = 0; i < 4; i++)
            slot_mem[8'h40 + i] = make_slot(4, i, (i == 0 || i == 2) ? 4'b0010 : 4'b0000);
        p0 = pop_nz;
        applyStimulus(16'h40, 16'd4, 16'h0, 16'd0);
        waitIdle();
        drain();
        checkOutput("t4_ch0_pops", pop_nz[0] - p0[0], 4);
        checkOutput("t4_ch1_pops", pop_nz[1] - p0[1], 2);
        checkOutput("t4_ch2_pops", pop_nz[2] - p0[2], 4);

        // Row_len only run.
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < CH; k++) len_mem[8'h50 + j][k*LEN_W +: LEN_W] = 16'(16'h0A00 + j*16 + k);
        l0 = pop_len;
        applyStimulus(16'h0, 16'd0, 16'h50, 16'd2);
        checkOutput("t5_len_addr0", {len_rd_en, len_addr}, {1'b1, 16'h0050});
        tick(1);
        checkOutput("t5_len_addr1", {len_rd_en, len_addr}, {1'b1, 16'h0051});
        tick(1);
        checkOutput("t5_done_early", done, 1'b0);
        tick(1);
        checkOutput("t5_done", done, 1'b1);
        tick(1);
        checkOutput("t5_ch0_head", row_len[15:0], 16'h0A00);
        checkOutput("t5_ch3_head", row_len[63:48], 16'h0A03);
        drain();
        for (int k = 0; k < CH; k++) checkOutput("t5_len_pops", pop_len[k] - l0[k], 2);

        // Empty run finishes two cycles after start.
        applyStimulus(16'h0, 16'd0, 16'h0, 16'd0);
        checkOutput("t5b_busy", {busy, done}, 2'b10);
        tick(1);
        checkOutput("t5b_done", done, 1'b1);
        tick(1);
        checkOutput("t5b_idle", busy, 1'b0);

        // Reset mid-run, then a fresh run.
        for (int i = 0; i < 6; i++) slot_mem[8'h60 + i] = make_slot(6, i, 4'b0000);
        for (int i = 0; i < 3; i++) slot_mem[8'h70 + i] = make_slot(7, i, 4'b1000);
        applyStimulus(16'h60, 16'd6, 16'h50, 16'd2);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("t6_nz_empty", nz_empty, 4'hF);
        checkOutput("t6_row_len_empty", row_len_empty, 4'hF);
        checkOutput("t6_busy", busy, 1'b0);
        p0 = pop_nz;
        applyStimulus(16'h70, 16'd3, 16'h0, 16'd0);
        waitIdle();
        drain();
        checkOutput("t6_ch0_pops", pop_nz[0] - p0[0], 3);
        checkOutput("t6_ch3_pops", pop_nz[3] - p0[3], 0);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
